piso_serializer: RTL and testbench

//  Parametrised parallel-in/serial-out shifter with a valid/ready load port, stall control and framing flags.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_serializer_if.sv | 29 ++
 rtl/piso_bitcnt.sv | 77 +++++++
 rtl/piso_serializer.sv | 133 +++++++++++++
 tb/tb_piso_serializer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//  - state_t / ST_IDLE / ST_SHIFT : FSM state encoding
//  - CNT_W()                      : width of the bit counter for a given word width
package piso_pkg;

    typedef logic state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Counter must hold WIDTH-1; WIDTH is at least 2 so this is never zero.
    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load/serial bundle of the serializer.
//  master : word producer / serial consumer side (drives load_valid, load_data,
//           shift_en, ser_in; observes ready and the serial outputs)
//  slave  : the serializer itself
// WIDTH here must match the WIDTH of the piso_serializer bound to it.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             ser_in;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_first;
    logic             frame_last;
    logic             busy;

    modport master (
        output load_valid, load_data, shift_en, ser_in,
        input  load_ready, ser_out, ser_valid, frame_first, frame_last, busy
    );

    modport slave (
        input  load_valid, load_data, shift_en, ser_in,
        output load_ready, ser_out, ser_valid, frame_first, frame_last, busy
    );
endinterface

// File: rtl/piso_bitcnt.sv
// Shift register plus remaining-bit counter of the serializer.
//  clk, rst_n    : clock, asynchronous active-low reset
//  load_i        : capture load_data_i and restart the count at WIDTH-1
//  dec_i         : shift one position (fill from ser_in_i) and count down
//  load_data_i   : parallel word
//  ser_in_i      : fill bit entering the vacated end
//  out_bit_o     : bit currently at the output end of the register
//  zero_o        : counter is 0 (last bit of the frame is on the output)
//  full_o        : counter is WIDTH-1 (first bit of the frame is on the output)
module piso_bitcnt
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ser_in_i,
    output logic             out_bit_o,
    output logic             zero_o,
    output logic             full_o
);
    localparam int            CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Next register/counter value: a load wins over a shift so the last-bit
    // cycle can both emit its bit and take the next word with no gap.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = load_data_i;
            cnt_d = CNT_MAX;
        end else if (dec_i) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], ser_in_i};
            end else begin
                sr_d = {ser_in_i, sr_q[WIDTH-1:1]};
            end
            // Shifting out the last bit leaves the count parked at zero.
            if (cnt_q == CNT_ZERO) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= {WIDTH{1'b0}};
            cnt_q <= CNT_ZERO;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign zero_o    = (cnt_q == CNT_ZERO);
    assign full_o    = (cnt_q == CNT_MAX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, stall and framing.
//  clk    : rising-edge clock
//  rst_n  : asynchronous active-low reset
//  bus    : piso_serializer_if.slave
//           load_valid/load_ready/load_data : word handshake
//           shift_en  : 1 advances one bit per clock, 0 freezes the frame
//           ser_in    : cascade fill bit
//           ser_out, ser_valid, frame_first, frame_last, busy : serial side
// Serial outputs decode registered state only; load_ready alone also
// depends on shift_en so a word can be taken on the last-bit cycle.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);
    state_t state_q;
    state_t state_d;

    logic out_bit_s;
    logic cnt_zero_s;
    logic cnt_full_s;
    logic load_ready_s;
    logic accept_s;
    logic advance_s;
    logic ser_out_s;
    logic ser_valid_s;
    logic frame_first_s;
    logic frame_last_s;

    piso_bitcnt #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_bitcnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept_s),
        .dec_i       (advance_s),
        .load_data_i (bus.load_data),
        .ser_in_i    (bus.ser_in),
        .out_bit_o   (out_bit_s),
        .zero_o      (cnt_zero_s),
        .full_o      (cnt_full_s)
    );

    // Handshake decode: ready in IDLE, or while the last bit leaves this cycle.
    always_comb begin
        load_ready_s = 1'b0;
        if (state_q == ST_IDLE) begin
            load_ready_s = 1'b1;
        end else if (cnt_zero_s && bus.shift_en) begin
            load_ready_s = 1'b1;
        end else begin
            load_ready_s = 1'b0;
        end
        accept_s  = bus.load_valid && load_ready_s;
        advance_s = (state_q == ST_SHIFT) && bus.shift_en;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (advance_s && cnt_zero_s) begin
                    state_d = accept_s ? ST_SHIFT : ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from registered state and counter only.
    always_comb begin
        ser_out_s     = IDLE_LEVEL;
        ser_valid_s   = 1'b0;
        frame_first_s = 1'b0;
        frame_last_s  = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                ser_out_s     = out_bit_s;
                ser_valid_s   = 1'b1;
                frame_first_s = cnt_full_s;
                frame_last_s  = cnt_zero_s;
            end
            ST_IDLE: begin
                ser_out_s     = IDLE_LEVEL;
                ser_valid_s   = 1'b0;
                frame_first_s = 1'b0;
                frame_last_s  = 1'b0;
            end
            default: begin
                ser_out_s     = IDLE_LEVEL;
                ser_valid_s   = 1'b0;
                frame_first_s = 1'b0;
                frame_last_s  = 1'b0;
            end
        endcase
    end

    assign bus.load_ready  = load_ready_s;
    assign bus.ser_out     = ser_out_s;
    assign bus.ser_valid   = ser_valid_s;
    assign bus.frame_first = frame_first_s;
    assign bus.frame_last  = frame_last_s;
    assign bus.busy        = ser_valid_s;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a per-cycle vector table driven into an
// MSB-first and an LSB-first instance, a bit-level scoreboard for streaming
// with stalls, a mid-frame reset sequence and a two-instance cascade.
module tb_piso_serializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_m ();
    piso_serializer_if #(.WIDTH(W)) if_l ();
    piso_serializer_if #(.WIDTH(W)) if_a ();
    piso_serializer_if #(.WIDTH(W)) if_b ();

    // Cascade: instance A feeds instance B.
    assign if_b.ser_in = if_a.ser_out;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(if_m.slave));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(if_l.slave));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_ca (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_cb (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    typedef struct {
        logic       lv;
        logic [7:0] d;
        logic       en;
        logic       em;   // expected ser_out, MSB-first instance (idle level 0)
        logic       el;   // expected ser_out, LSB-first instance (idle level 1)
        logic       ev;   // ser_valid / busy
        logic       ef;   // frame_first
        logic       ela;  // frame_last
        logic       er;   // load_ready
    } vec_t;

    vec_t vecs[$];
    logic exp_q[$];
    logic [7:0] words[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add_idle(input logic lv, input logic [7:0] d, input logic en);
        vec_t v;
        v.lv = lv; v.d = d; v.en = en;
        v.em = 1'b0; v.el = 1'b1; v.ev = 1'b0; v.ef = 1'b0; v.ela = 1'b0; v.er = 1'b1;
        vecs.push_back(v);
    endtask

    // One frame of d; stall_len stalled cycles are inserted before bit stall_at
    // becomes advancing, and the last-bit cycle offers (nlv, nd).
    task automatic add_frame(input logic [7:0] d, input int stall_at, input int stall_len,
                             input logic nlv, input logic [7:0] nd);
        vec_t v;
        for (int k = 1; k <= 8; k++) begin
            v.em  = d[8-k];
            v.el  = d[k-1];
            v.ev  = 1'b1;
            v.ef  = (k == 1);
            v.ela = (k == 8);
            v.lv  = (k == 8) ? nlv : 1'b0;
            v.d   = (k == 8) ? nd : 8'h00;
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    v.en = 1'b0; v.er = 1'b0;
                    vecs.push_back(v);
                end
            end
            v.en = 1'b1;
            v.er = (k == 8);
            vecs.push_back(v);
        end
    endtask

    // Streams words[] through the MSB-first instance; expected bits are
    // queued on each accepted word and popped on each advancing cycle.
    task automatic run_sb(input bit rand_stall, input int limit);
        int wi;
        int budget;
        logic en_now;
        logic [7:0] w;
        logic b;
        wi = 0;
        budget = 0;
        while ((wi < words.size() || exp_q.size() > 0) && budget < limit) begin
            @(negedge clk);
            en_now = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if_m.shift_en   = en_now;
            if_m.load_valid = (wi < words.size());
            if_m.load_data  = (wi < words.size()) ? words[wi] : 8'h00;
            #1;
            if (exp_q.size() > 0) chk("sb_nogap", if_m.ser_valid, 1'b1);
            if (if_m.ser_valid && en_now) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    b = exp_q.pop_front();
                    chk("sb_bit", if_m.ser_out, b);
                end
            end
            if (if_m.load_valid && if_m.load_ready) begin
                w = words[wi];
                for (int k = 7; k >= 0; k--) exp_q.push_back(w[k]);
                wi++;
            end
            budget++;
        end
        chk("sb_timeout", (budget < limit), 1'b1);
        chk("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        if_m.load_valid = 1'b0;
        if_m.shift_en   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] w5;
        rst_n = 1'b0;
        if_m.load_valid = 1'b0; if_m.load_data = 8'h00; if_m.shift_en = 1'b0; if_m.ser_in = 1'b0;
        if_l.load_valid = 1'b0; if_l.load_data = 8'h00; if_l.shift_en = 1'b0; if_l.ser_in = 1'b1;
        if_a.load_valid = 1'b0; if_a.load_data = 8'h00; if_a.shift_en = 1'b0; if_a.ser_in = 1'b0;
        if_b.load_valid = 1'b0; if_b.load_data = 8'h00; if_b.shift_en = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_m", if_m.ser_out, 1'b0);
        chk("rst_out_l", if_l.ser_out, 1'b1);
        chk("rst_valid", if_m.ser_valid, 1'b0);
        chk("rst_first", if_m.frame_first, 1'b0);
        chk("rst_last", if_m.frame_last, 1'b0);
        chk("rst_busy", if_m.busy, 1'b0);
        chk("rst_ready", if_m.load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        add_idle(1'b0, 8'h00, 1'b1);
        add_idle(1'b1, 8'hA5, 1'b1);
        add_frame(8'hA5, 0, 0, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00, 1'b1);
        add_idle(1'b1, 8'h12, 1'b1);
        add_frame(8'h12, 0, 0, 1'b1, 8'h34);
        add_frame(8'h34, 8, 2, 1'b1, 8'h56);
        add_frame(8'h56, 0, 0, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00, 1'b1);
        add_idle(1'b1, 8'hC3, 1'b0);
        add_frame(8'hC3, 3, 3, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            if_m.load_valid = vecs[i].lv; if_m.load_data = vecs[i].d; if_m.shift_en = vecs[i].en;
            if_l.load_valid = vecs[i].lv; if_l.load_data = vecs[i].d; if_l.shift_en = vecs[i].en;
            #1;
            chk($sformatf("v%0d_out_m", i), if_m.ser_out, vecs[i].em);
            chk($sformatf("v%0d_out_l", i), if_l.ser_out, vecs[i].el);
            chk($sformatf("v%0d_valid_m", i), if_m.ser_valid, vecs[i].ev);
            chk($sformatf("v%0d_valid_l", i), if_l.ser_valid, vecs[i].ev);
            chk($sformatf("v%0d_busy", i), if_m.busy, vecs[i].ev);
            chk($sformatf("v%0d_first", i), if_m.frame_first, vecs[i].ef);
            chk($sformatf("v%0d_last", i), if_l.frame_last, vecs[i].ela);
            chk($sformatf("v%0d_ready_m", i), if_m.load_ready, vecs[i].er);
            chk($sformatf("v%0d_ready_l", i), if_l.load_ready, vecs[i].er);
        end
        @(negedge clk);
        if_m.load_valid = 1'b0; if_l.load_valid = 1'b0;
        if_m.shift_en = 1'b1;   if_l.shift_en = 1'b1;

        // Back-to-back stream with load_valid held, then random stalls.
        words.delete();
        words.push_back(8'hF0);
        words.push_back(8'h0F);
        run_sb(1'b0, 100);
        words.delete();
        for (int i = 0; i < 5; i++) begin
            w5 = 8'($urandom_range(0, 255));
            words.push_back(w5);
        end
        run_sb(1'b1, 300);

        // Reset in the middle of a frame, then a clean restart.
        @(negedge clk);
        if_m.load_valid = 1'b1; if_m.load_data = 8'hA5; if_m.shift_en = 1'b1;
        @(negedge clk);
        if_m.load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_bit4", if_m.ser_out, 1'b0);
        chk("t5_busy4", if_m.busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out", if_m.ser_out, 1'b0);
        chk("t5_rst_valid", if_m.ser_valid, 1'b0);
        chk("t5_rst_busy", if_m.busy, 1'b0);
        chk("t5_rst_ready", if_m.load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        if_m.load_valid = 1'b1; if_m.load_data = 8'h81;
        @(negedge clk);
        if_m.load_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            w5 = 8'h81;
            chk($sformatf("t5_re_bit%0d", k), if_m.ser_out, w5[8-k]);
            chk($sformatf("t5_re_first%0d", k), if_m.frame_first, (k == 1));
            chk($sformatf("t5_re_last%0d", k), if_m.frame_last, (k == 8));
        end

        // Cascade: A(0xFF) feeds B(0x00).
        @(negedge clk);
        if_a.load_valid = 1'b1; if_a.load_data = 8'hFF; if_a.shift_en = 1'b1;
        if_b.load_valid = 1'b1; if_b.load_data = 8'h00; if_b.shift_en = 1'b1;
        @(negedge clk);
        if_a.load_valid = 1'b0; if_b.load_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk($sformatf("t6_b_bit%0d", k), if_b.ser_out, 1'b0);
            chk($sformatf("t6_a_bit%0d", k), if_a.ser_out, 1'b1);
            chk($sformatf("t6_b_valid%0d", k), if_b.ser_valid, 1'b1);
        end
        @(negedge clk);
        #1;
        chk("t6_b_idle", if_b.ser_valid, 1'b0);
        chk("t6_b_captured", u_cb.u_bitcnt.sr_q, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
